// File: rtl/sensor_emulator_if.sv
// AHB-Lite slave-side signal bundle for the hall-sensor emulator.
// Clock and reset stay plain ports on the modules that use this bundle.
interface sensor_emulator_if;
  logic        HSEL;
  logic        HREADY;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HSEL, HREADY, HWRITE, HADDR, HWDATA, HSIZE, HTRANS,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HSEL, HREADY, HWRITE, HADDR, HWDATA, HSIZE, HTRANS,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/sensor_emulator.sv
// Hall-sensor pulse emulator: an AHB-Lite zero-wait-state slave that produces
// active-low nFork / nCrank pulse trains with periods in 1 ms ticks and a
// programmable low-pulse width in HCLK cycles.
module sensor_emulator #(
  parameter int TICK_CYCLES = 33,
  parameter int MIN_PULSE   = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  sensor_emulator_if.slave ahb,
  output logic             nFork,
  output logic             nCrank
);

  localparam int              PS_W      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PS_W-1:0] TICK_LAST = PS_W'(TICK_CYCLES - 1);
  localparam logic [7:0]      MIN_PW    = 8'(MIN_PULSE);

  localparam logic [2:0] IDX_CTRL    = 3'd0;
  localparam logic [2:0] IDX_FORK    = 3'd1;
  localparam logic [2:0] IDX_CRANK   = 3'd2;
  localparam logic [2:0] IDX_PULSE   = 3'd3;
  localparam logic [2:0] IDX_STATUS  = 3'd4;
  localparam logic [2:0] IDX_OVERRUN = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } ch_state_t;

  // Bus pipeline
  logic        w_aphase;
  logic        r_dp_valid;
  logic        r_dp_write;
  logic [2:0]  r_dp_idx;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_status;

  // Configuration
  logic [1:0]  r_ctrl;
  logic [15:0] r_fork_period;
  logic [15:0] r_crank_period;
  logic [7:0]  r_pulse_width;
  logic [7:0]  w_pw_eff;

  // Timebase
  logic [PS_W-1:0] r_presc;
  logic            w_tick;

  // Per-channel views (index 0 = fork, 1 = crank)
  logic [1:0][15:0] w_period;
  logic [1:0][15:0] w_count;
  logic [1:0]       w_ovr;
  logic [1:0]       w_out;

  logic w_unused;

  assign w_unused = ^{ahb.HSIZE, ahb.HADDR[31:5], ahb.HADDR[1:0], ahb.HWDATA[31:16]};

  assign w_aphase    = ahb.HSEL && ahb.HREADY && (ahb.HTRANS != 2'b00);
  assign w_wr        = r_dp_valid && r_dp_write;
  assign w_wr_ctrl   = w_wr && (r_dp_idx == IDX_CTRL);
  assign w_wr_status = w_wr && (r_dp_idx == IDX_STATUS);

  assign ahb.HREADYOUT = 1'b1;

  // Capture a valid address phase so the following cycle is its data phase.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_idx   <= 3'd0;
    end else begin
      r_dp_valid <= w_aphase;
      if (w_aphase) begin
        r_dp_write <= ahb.HWRITE;
        r_dp_idx   <= ahb.HADDR[4:2];
      end
    end
  end

  // Writable configuration registers, updated at the end of the data phase.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_ctrl         <= 2'b00;
      r_fork_period  <= 16'd0;
      r_crank_period <= 16'd0;
      r_pulse_width  <= MIN_PW;
    end else if (w_wr) begin
      case (r_dp_idx)
        IDX_CTRL:  r_ctrl         <= ahb.HWDATA[1:0];
        IDX_FORK:  r_fork_period  <= ahb.HWDATA[15:0];
        IDX_CRANK: r_crank_period <= ahb.HWDATA[15:0];
        IDX_PULSE: r_pulse_width  <= ahb.HWDATA[7:0];
        default:   ;
      endcase
    end
  end

  // 1 ms prescaler; a CTRL write restarts it so enable-to-pulse timing is exact.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_presc <= '0;
    end else if (w_wr_ctrl || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick   = (r_presc == TICK_LAST);
  assign w_pw_eff = (r_pulse_width < MIN_PW) ? MIN_PW : r_pulse_width;

  assign w_period[0] = r_fork_period;
  assign w_period[1] = r_crank_period;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    ch_state_t   r_state;
    ch_state_t   w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [15:0] r_count;
    logic [15:0] w_count_nxt;
    logic [7:0]  r_wid;
    logic [7:0]  w_wid_nxt;
    logic        r_ovr;
    logic        w_ovr_nxt;
    logic        r_out;
    logic        w_out_nxt;
    logic        w_run;
    logic        w_hit;

    assign w_run = r_ctrl[gi] && (w_period[gi] != 16'd0);
    assign w_hit = w_tick && (r_cnt == (w_period[gi] - 16'd1));

    // Channel state, counters and the registered sensor pin.
    always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
        r_state <= ST_IDLE;
        r_cnt   <= 16'd0;
        r_count <= 16'd0;
        r_wid   <= 8'd0;
        r_ovr   <= 1'b0;
        r_out   <= 1'b1;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_count <= w_count_nxt;
        r_wid   <= w_wid_nxt;
        r_ovr   <= w_ovr_nxt;
        r_out   <= w_out_nxt;
      end
    end

    // Next state: the pin follows the state one cycle later, except that a
    // disable forces it high on the very next edge.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_count_nxt = r_count;
      w_wid_nxt   = r_wid;
      w_ovr_nxt   = r_ovr;
      w_out_nxt   = (r_state != ST_LOW);
      if (!w_run) begin
        w_state_nxt = ST_IDLE;
        w_out_nxt   = 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_cnt_nxt   = 16'd0;
            w_state_nxt = ST_HIGH;
          end
          ST_HIGH: begin
            if (w_hit) begin
              w_cnt_nxt   = 16'd0;
              w_wid_nxt   = w_pw_eff - 8'd1;
              w_count_nxt = r_count + 16'd1;
              w_state_nxt = ST_LOW;
            end else if (w_tick) begin
              w_cnt_nxt = r_cnt + 16'd1;
            end
          end
          ST_LOW: begin
            // A fire while still low is dropped and flagged as overrun.
            if (w_hit) begin
              w_cnt_nxt = 16'd0;
              w_ovr_nxt = 1'b1;
            end else if (w_tick) begin
              w_cnt_nxt = r_cnt + 16'd1;
            end
            if (r_wid == 8'd0) begin
              w_state_nxt = ST_HIGH;
            end else begin
              w_wid_nxt = r_wid - 8'd1;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_out_nxt   = 1'b1;
          end
        endcase
      end
      // Clearing via STATUS takes priority over a same-edge increment.
      if (w_wr_status) begin
        w_count_nxt = 16'd0;
        w_ovr_nxt   = 1'b0;
      end
    end

    assign w_count[gi] = r_count;
    assign w_ovr[gi]   = r_ovr;
    assign w_out[gi]   = r_out;
  end

  assign nFork  = w_out[0];
  assign nCrank = w_out[1];

  // Read data is driven only during a read data phase.
  always_comb begin
    ahb.HRDATA = 32'd0;
    if (r_dp_valid && !r_dp_write) begin
      case (r_dp_idx)
        IDX_CTRL:    ahb.HRDATA = {30'd0, r_ctrl};
        IDX_FORK:    ahb.HRDATA = {16'd0, r_fork_period};
        IDX_CRANK:   ahb.HRDATA = {16'd0, r_crank_period};
        IDX_PULSE:   ahb.HRDATA = {24'd0, r_pulse_width};
        IDX_STATUS:  ahb.HRDATA = {w_count[1], w_count[0]};
        IDX_OVERRUN: ahb.HRDATA = {30'd0, w_ovr};
        default:     ahb.HRDATA = 32'd0;
      endcase
    end
  end

endmodule
